// File: rtl/dl_reset_seq.sv
// Download front-end for the blockade core: forwards ROM bytes, latches game_mode and DIPs,
// and keeps the core in reset until a non-blank ROM has loaded and a fixed hold time has elapsed.
module dl_reset_seq #(
  parameter int ROM_AW      = 14,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ext_reset,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [1:0]        game_mode,
  output logic [63:0]       dip_sw,
  output logic              core_reset,
  output logic              rom_ok,
  output logic              rom_busy,
  output logic              addr_ovf
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_reset_q, core_reset_d;
  logic              rom_ok_q, rom_ok_d;
  logic              rom_busy_q, rom_busy_d;
  logic              blk_q, blk_d;
  logic              nz_q, nz_d;
  logic              addr_ovf_q, addr_ovf_d;
  logic              dn_wr_q, dn_wr_d;
  logic [ROM_AW-1:0] dn_addr_q, dn_addr_d;
  logic [7:0]        dn_data_q, dn_data_d;
  logic [1:0]        game_mode_q, game_mode_d;
  logic [63:0]       dip_sw_q, dip_sw_d;

  logic rom_dl;
  logic addr_in_rom;
  logic rom_wr;
  logic rom_fwd;
  logic dl_rise;
  logic dl_fall;
  logic gm_wr;
  logic gm_chg;
  logic dip_wr;

  // blk_q suppresses a download that was already in flight when reset_n was asserted;
  // it clears only once the download line has been seen low.
  always_comb begin
    rom_dl      = ioctl_download & (ioctl_index == 8'd0);
    addr_in_rom = (ioctl_addr[24:ROM_AW] == '0);
    rom_wr      = ioctl_wr & rom_dl & ~blk_q;
    rom_fwd     = rom_wr & addr_in_rom;
    dl_rise     = rom_dl & ~rom_busy_q & ~blk_q;
    dl_fall     = ~rom_dl & rom_busy_q & ~blk_q;
    gm_wr       = ioctl_wr & (ioctl_index == 8'd1);
    gm_chg      = gm_wr & (ioctl_dout[1:0] != game_mode_q);
    dip_wr      = ioctl_wr & (ioctl_index == 8'd254) & (ioctl_addr[24:3] == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (dl_rise) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_LOAD: begin
          if (dl_fall) begin
            state_d = nz_q ? S_HOLD : S_FAIL;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (ext_reset) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (ext_reset || gm_chg) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
        S_FAIL: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // core_reset rises as soon as RUN is left and falls one cycle after RUN is entered,
  // which stretches the released edge to HOLD_CYCLES+1 cycles after the HOLD entry edge.
  always_comb begin
    core_reset_d = (state_d != S_RUN) | (state_q != S_RUN);
    rom_ok_d     = (state_d == S_RUN) | (rom_ok_q & (state_d == S_HOLD));
    rom_busy_d   = rom_dl;
    blk_d        = blk_q & rom_dl;
    nz_d         = (dl_rise ? 1'b0 : nz_q) | (rom_fwd & (ioctl_dout != 8'd0));
    addr_ovf_d   = (dl_rise ? 1'b0 : addr_ovf_q) | (rom_wr & ~addr_in_rom);
    dn_wr_d      = rom_fwd;
    dn_addr_d    = rom_fwd ? ioctl_addr[ROM_AW-1:0] : dn_addr_q;
    dn_data_d    = rom_fwd ? ioctl_dout : dn_data_q;
    game_mode_d  = gm_wr ? ioctl_dout[1:0] : game_mode_q;
    dip_sw_d     = dip_sw_q;
    if (dip_wr) begin
      dip_sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      rom_ok_q     <= 1'b0;
      rom_busy_q   <= 1'b0;
      blk_q        <= rom_dl;
      nz_q         <= 1'b0;
      addr_ovf_q   <= 1'b0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      game_mode_q  <= '0;
      dip_sw_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
      rom_ok_q     <= rom_ok_d;
      rom_busy_q   <= rom_busy_d;
      blk_q        <= blk_d;
      nz_q         <= nz_d;
      addr_ovf_q   <= addr_ovf_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      game_mode_q  <= game_mode_d;
      dip_sw_q     <= dip_sw_d;
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign game_mode  = game_mode_q;
  assign dip_sw     = dip_sw_q;
  assign core_reset = core_reset_q;
  assign rom_ok     = rom_ok_q;
  assign rom_busy   = rom_busy_q;
  assign addr_ovf   = addr_ovf_q;

endmodule

// File: tb/tb_dl_reset_seq.sv
// Directed bench for dl_reset_seq: a timestamp-based model checked every cycle plus literal checks.
module tb_dl_reset_seq;
  localparam int AW = 14;
  localparam int H  = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ext_reset;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic          dn_wr;
  logic [1:0]    game_mode;
  logic [63:0]   dip_sw;
  logic          core_reset;
  logic          rom_ok;
  logic          rom_busy;
  logic          addr_ovf;

  dl_reset_seq #(.ROM_AW(AW), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ext_reset(ext_reset), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .game_mode(game_mode), .dip_sw(dip_sw), .core_reset(core_reset), .rom_ok(rom_ok),
    .rom_busy(rom_busy), .addr_ovf(addr_ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_dnwr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model state: outputs plus timestamps instead of an explicit state machine.
  bit          m_busy, m_blk, m_dnwr, m_ovf, m_nz, m_cr = 1'b1, m_ok;
  bit          m_loading, m_good, m_reached;
  logic [AW-1:0] m_dnaddr;
  logic [7:0]  m_dndata;
  logic [1:0]  m_gm;
  logic [63:0] m_dip;
  int          m_release;

  always @(posedge clk) begin : compare
    bit rd, rise, fall, fwd, ovfw, gchg, sb, sa;
    #1;
    cyc++;
    rd = ioctl_download && (ioctl_index == 8'd0);
    if (!reset_n) begin
      m_blk = rd; m_busy = 0; m_dnwr = 0; m_dnaddr = '0; m_dndata = '0; m_gm = '0; m_dip = '0;
      m_ovf = 0; m_nz = 0; m_loading = 0; m_good = 0; m_reached = 0; m_cr = 1; m_ok = 0;
    end else begin
      rise = rd && !m_busy && !m_blk;
      fall = !rd && m_busy && !m_blk;
      fwd  = ioctl_wr && rd && !m_blk && (ioctl_addr < 25'(1 << AW));
      ovfw = ioctl_wr && rd && !m_blk && (ioctl_addr >= 25'(1 << AW));
      gchg = ioctl_wr && (ioctl_index == 8'd1) && (ioctl_dout[1:0] != m_gm);
      // Running before this edge: validated ROM and the release time already passed.
      sb = m_good && !m_loading && (cyc - 1 >= m_release);
      if (rise) begin
        m_loading = 1; m_good = 0; m_reached = 0; m_nz = 0; m_ovf = 0;
      end else if (m_loading && fall) begin
        m_loading = 0; m_good = m_nz; m_release = cyc + H;
      end else if (m_good && (ext_reset || (sb && gchg))) begin
        m_release = cyc + H;
      end
      sa = m_good && !m_loading && (cyc >= m_release);
      m_cr = !(sa && sb);
      if (sa) m_reached = 1;
      m_ok = m_good && m_reached;
      if (fwd && ioctl_dout != 8'd0) m_nz = 1;
      if (ovfw) m_ovf = 1;
      m_dnwr = fwd;
      if (fwd) begin m_dnaddr = ioctl_addr[AW-1:0]; m_dndata = ioctl_dout; end
      if (ioctl_wr && ioctl_index == 8'd1) m_gm = ioctl_dout[1:0];
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
        m_dip[ioctl_addr[2:0]*8 +: 8] = ioctl_dout;
      m_busy = rd;
      m_blk  = m_blk && rd;
    end
    if (dn_wr) n_dnwr++;
    chk($sformatf("cycle %0d outputs", cyc),
        {dn_wr, dn_addr, dn_data, game_mode, dip_sw, core_reset, rom_ok, rom_busy, addr_ovf},
        {m_dnwr, m_dnaddr, m_dndata, m_gm, m_dip, m_cr, m_ok, m_busy, m_ovf});
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_release(input int ev, input string name);
    int k = 0;
    while (core_reset && k < H + 20) begin
      step();
      k++;
    end
    chk({name, " released"}, core_reset, 1'b0);
    chk({name, " latency"}, cyc - ev, H + 1);
  endtask

  task automatic rom_load(input int nbytes, input bit mark);
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    for (int i = 0; i < nbytes; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = (mark && i == 'h100) ? 8'h3C : 8'h00;
      step();
      if (mark && i == 'h100) begin
        chk("dn_wr at 0x100", dn_wr, 1'b1);
        chk("dn_addr at 0x100", dn_addr, 14'h0100);
        chk("dn_data at 0x100", dn_data, 8'h3C);
      end
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base, ev;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = '0; ext_reset = 1'b0;
    repeat (3) step();
    chk("reset core_reset", core_reset, 1'b1);
    chk("reset rom_ok", rom_ok, 1'b0);
    chk("reset dn_wr/addr/data", {dn_wr, dn_addr, dn_data}, '0);
    chk("reset game_mode/dip", {game_mode, dip_sw}, '0);
    chk("reset busy/ovf", {rom_busy, addr_ovf}, '0);
    reset_n = 1'b1;
    repeat (2) step();

    // All-zero 16 KiB ROM: every byte forwarded, core stays in reset.
    base = n_dnwr;
    rom_load(16384, 1'b0);
    chk("zero rom busy", rom_busy, 1'b1);
    ioctl_download = 1'b0;
    repeat (H + 5) step();
    chk("zero rom dn_wr count", n_dnwr - base, 16384);
    chk("zero rom core_reset", core_reset, 1'b1);
    chk("zero rom rom_ok", rom_ok, 1'b0);

    // ROM with one marker byte: released HOLD_CYCLES+1 cycles after download drop.
    rom_load(16384, 1'b1);
    ioctl_download = 1'b0;
    ev = cyc + 1;
    step();
    wait_release(ev, "rom load");
    chk("rom load rom_ok", rom_ok, 1'b1);
    repeat (3) step();

    // Single-cycle ext_reset pulse.
    ext_reset = 1'b1;
    ev = cyc + 1;
    step();
    ext_reset = 1'b0;
    chk("ext pulse core_reset", core_reset, 1'b1);
    chk("ext pulse rom_ok held", rom_ok, 1'b1);
    wait_release(ev, "ext pulse");
    repeat (3) step();

    // ext_reset held for 50 cycles restarts the hold every cycle.
    ext_reset = 1'b1;
    repeat (50) step();
    ev = cyc;
    ext_reset = 1'b0;
    chk("ext hold core_reset", core_reset, 1'b1);
    wait_release(ev, "ext hold");
    repeat (3) step();

    // game_mode change in RUN re-enters hold; same low bits do not.
    ev = cyc + 1;
    wr_byte(8'd1, 25'd0, 8'h02);
    chk("game_mode 2", game_mode, 2'd2);
    chk("game_mode change reset", core_reset, 1'b1);
    wait_release(ev, "game_mode change");
    wr_byte(8'd1, 25'd0, 8'h06);
    repeat (5) step();
    chk("game_mode same value", game_mode, 2'd2);
    chk("game_mode same no reset", core_reset, 1'b0);

    // DIP bytes 0..7 plus an out-of-range address.
    for (int i = 0; i < 8; i++) wr_byte(8'd254, 25'(i), 8'((i + 1) * 17));
    wr_byte(8'd254, 25'd8, 8'hFF);
    step();
    chk("dip_sw value", dip_sw, 64'h8877665544332211);
    chk("dip core_reset", core_reset, 1'b0);

    // Overflowing ROM address: dropped and flagged; blank ROM then fails.
    ioctl_download = 1'b1;
    wr_byte(8'd0, 25'd0, 8'h00);
    wr_byte(8'd0, 25'h4000, 8'h55);
    chk("ovf no dn_wr", dn_wr, 1'b0);
    chk("ovf flag", addr_ovf, 1'b1);
    chk("ovf dn_addr held", dn_addr, 14'h0000);
    ioctl_download = 1'b0;
    repeat (H + 5) step();
    chk("ovf fail core_reset", core_reset, 1'b1);
    chk("ovf fail rom_ok", rom_ok, 1'b0);
    chk("ovf sticky", addr_ovf, 1'b1);

    // New download from FAIL with ext_reset in the same cycle.
    ioctl_download = 1'b1; ioctl_index = 8'd0; ext_reset = 1'b1;
    step();
    ext_reset = 1'b0;
    chk("restart ovf cleared", addr_ovf, 1'b0);
    chk("restart busy", rom_busy, 1'b1);
    chk("restart core_reset", core_reset, 1'b1);
    wr_byte(8'd0, 25'd3, 8'h00);
    ioctl_download = 1'b0;
    repeat (H + 5) step();
    chk("restart blank fails", core_reset, 1'b1);

    // Reset in the middle of a download: the rest is not forwarded.
    ioctl_download = 1'b1;
    wr_byte(8'd0, 25'd5, 8'h10);
    reset_n = 1'b0;
    wr_byte(8'd0, 25'd6, 8'h11);
    reset_n = 1'b1;
    wr_byte(8'd0, 25'd7, 8'h20);
    chk("midreset no dn_wr", dn_wr, 1'b0);
    chk("midreset dn_addr", dn_addr, 14'h0000);
    ioctl_download = 1'b0;
    repeat (H + 5) step();
    chk("midreset core_reset", core_reset, 1'b1);
    chk("midreset busy", rom_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
